// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the IF stage of the MUSA core.
//
// Holds the word-addressed fetch PC and picks the next PC each cycle from:
// exception vector, stall hold, absolute jump, call (jump + push of the return
// address), return (pop of a circular return-address stack), PC-relative
// branch, or sequential increment, in that priority order.  A registered
// one-cycle redirect flag tells the pipeline to flush IF/ID after any
// non-sequential PC load.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset (overrides everything)
//   pc_write      in   1 = PC may advance, 0 = stall (PC and RAS hold)
//   exc_req       in   exception redirect; taken even while stalled
//   jump_en       in   PC <= jump_target
//   call_en       in   PC <= jump_target, push pc_out+1
//   ret_en        in   PC <= popped return address
//   branch_en     in   PC <= pc_out + sext(branch_off)
//   jump_target   in   [AW-1:0]   absolute target for jump/call
//   branch_off    in   [OFFW-1:0] signed word offset relative to pc_out
//   pc_out        out  [AW-1:0]   current fetch address (registered)
//   redirect      out  registered, high the cycle after a non-sequential load
//   ras_count     out  [CW-1:0]   valid RAS entries, 0..RAS_DEPTH
//   ras_overflow  out  registered one-cycle pulse: push while full
//   ras_underflow out  registered one-cycle pulse: pop while empty
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int            AW           = 13,
  parameter int            OFFW         = 16,
  parameter logic [AW-1:0] RESET_VECTOR = '0,
  parameter logic [AW-1:0] EXC_VECTOR   = AW'(1),
  parameter int            RAS_DEPTH    = 4,
  localparam int           PW           = $clog2(RAS_DEPTH),
  localparam int           CW           = PW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            exc_req,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic            branch_en,
  input  logic [AW-1:0]   jump_target,
  input  logic [OFFW-1:0] branch_off,
  output logic [AW-1:0]   pc_out,
  output logic            redirect,
  output logic [CW-1:0]   ras_count,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  // Branch arithmetic is done in the wider of AW/OFFW so the offset is
  // sign-extended before the add; only the low AW bits are kept (mod 2^AW).
  localparam int EW = (OFFW > AW) ? OFFW : AW;

  // RAS: circular buffer. sp points at the next slot to write, so the top
  // entry lives at sp-1. When full, sp also points at the oldest entry, which
  // is exactly the one a push must overwrite.
  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_dec;

  logic [AW-1:0] pc_inc;
  logic [EW-1:0] br_sum;
  logic [AW-1:0] br_target;
  logic          ras_full;
  logic          ras_empty;

  // Next-state values
  logic [AW-1:0] pc_next;
  logic          redirect_next;
  logic [CW-1:0] count_next;
  logic [PW-1:0] sp_next;
  logic          ovf_next;
  logic          unf_next;
  logic          push;

  assign sp_dec    = sp - PW'(1);
  assign pc_inc    = pc_out + AW'(1);
  assign br_sum    = EW'(pc_out) + EW'($signed(branch_off));
  assign br_target = br_sum[AW-1:0];
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  // High bits of the wide branch sum are intentionally discarded.
  generate
    if (EW > AW) begin : g_br_trunc
      logic br_sum_unused;
      assign br_sum_unused = ^br_sum[EW-1:AW];
    end
  endgenerate

  always_comb begin
    pc_next       = pc_out;
    redirect_next = 1'b0;
    count_next    = ras_count;
    sp_next       = sp;
    ovf_next      = 1'b0;
    unf_next      = 1'b0;
    push          = 1'b0;

    if (exc_req) begin
      pc_next       = EXC_VECTOR;
      redirect_next = 1'b1;
    end else if (!pc_write) begin
      // Stall: hold PC and RAS; pulses and redirect fall to 0.
      pc_next = pc_out;
    end else if (jump_en) begin
      pc_next       = jump_target;
      redirect_next = 1'b1;
    end else if (call_en) begin
      pc_next       = jump_target;
      redirect_next = 1'b1;
      push          = 1'b1;
      sp_next       = sp + PW'(1);
      if (ras_full) begin
        ovf_next = 1'b1;
      end else begin
        count_next = ras_count + CW'(1);
      end
    end else if (ret_en) begin
      if (!ras_empty) begin
        pc_next       = ras_mem[sp_dec];
        redirect_next = 1'b1;
        sp_next       = sp_dec;
        count_next    = ras_count - CW'(1);
      end else begin
        // Return with nothing to return to: fall through sequentially.
        pc_next  = pc_inc;
        unf_next = 1'b1;
      end
    end else if (branch_en) begin
      pc_next       = br_target;
      redirect_next = 1'b1;
    end else begin
      pc_next = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out        <= RESET_VECTOR;
      redirect      <= 1'b0;
      ras_count     <= '0;
      sp            <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_out        <= pc_next;
      redirect      <= redirect_next;
      ras_count     <= count_next;
      sp            <= sp_next;
      ras_overflow  <= ovf_next;
      ras_underflow <= unf_next;
    end
  end

  // Entry contents need no reset; they are only read when ras_count > 0.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_mem[sp] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam int AW        = 13;
  localparam int OFFW      = 16;
  localparam int RAS_DEPTH = 4;
  localparam int CW        = $clog2(RAS_DEPTH) + 1;

  logic            clk;
  logic            reset;
  logic            pc_write;
  logic            exc_req;
  logic            jump_en;
  logic            call_en;
  logic            ret_en;
  logic            branch_en;
  logic [AW-1:0]   jump_target;
  logic [OFFW-1:0] branch_off;
  logic [AW-1:0]   pc_out;
  logic            redirect;
  logic [CW-1:0]   ras_count;
  logic            ras_overflow;
  logic            ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(
    .AW           (AW),
    .OFFW         (OFFW),
    .RESET_VECTOR (13'h100),
    .EXC_VECTOR   (13'h004),
    .RAS_DEPTH    (RAS_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .exc_req       (exc_req),
    .jump_en       (jump_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .branch_en     (branch_en),
    .jump_target   (jump_target),
    .branch_off    (branch_off),
    .pc_out        (pc_out),
    .redirect      (redirect),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset       = 1'b0;
    pc_write    = 1'b1;
    exc_req     = 1'b0;
    jump_en     = 1'b0;
    call_en     = 1'b0;
    ret_en      = 1'b0;
    branch_en   = 1'b0;
    jump_target = '0;
    branch_off  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an arbitrary PC with a jump, then return inputs to idle.
  task automatic goto_pc(input logic [AW-1:0] target);
    idle_inputs();
    jump_en     = 1'b1;
    jump_target = target;
    tick();
    idle_inputs();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [AW-1:0] exp_pc;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (pc_out !== 13'h100) begin
      n_fail++; $display("FAIL reset_pc: got %h exp %h", pc_out, 13'h100);
    end
    n_checks++;
    if ({redirect, ras_overflow, ras_underflow} !== 3'b000 || ras_count !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got redir=%b ovf=%b unf=%b cnt=%0d exp 0/0/0/0",
               redirect, ras_overflow, ras_underflow, ras_count);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_pc = 13'h100 + AW'(i);
      n_checks++;
      if (pc_out !== exp_pc || redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_%0d: got pc=%h redir=%b exp pc=%h redir=0",
                 i, pc_out, redirect, exp_pc);
      end
    end
    // Push one entry, then reset while a call is also requested.
    call_en     = 1'b1;
    jump_target = 13'h0A0;
    tick();
    idle_inputs();
    n_checks++;
    if (ras_count !== CW'(1)) begin
      n_fail++; $display("FAIL reset_pre_count: got %0d exp 1", ras_count);
    end
    reset       = 1'b1;
    call_en     = 1'b1;
    jump_target = 13'h0B0;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h100 || ras_count !== '0 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got pc=%h cnt=%0d redir=%b exp pc=100 cnt=0 redir=0",
               pc_out, ras_count, redirect);
    end
  endtask

  task automatic test_branch();
    goto_pc(13'h010);
    n_checks++;
    if (pc_out !== 13'h010 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL jump_load: got pc=%h redir=%b exp 010/1", pc_out, redirect);
    end
    branch_en  = 1'b1;
    branch_off = 16'hFFFC;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h00C || redirect !== 1'b1) begin
      n_fail++; $display("FAIL branch_neg: got pc=%h redir=%b exp 00c/1", pc_out, redirect);
    end
    tick();
    n_checks++;
    if (pc_out !== 13'h00D || redirect !== 1'b0) begin
      n_fail++; $display("FAIL branch_after: got pc=%h redir=%b exp 00d/0", pc_out, redirect);
    end
    branch_en  = 1'b1;
    branch_off = 16'h0005;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h012 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL branch_pos: got pc=%h redir=%b exp 012/1", pc_out, redirect);
    end
    // Increment wraps from 0x1FFF to 0.
    goto_pc(13'h1FFF);
    tick();
    n_checks++;
    if (pc_out !== 13'h0000 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL inc_wrap: got pc=%h redir=%b exp 0000/0", pc_out, redirect);
    end
    // Negative branch from 0 wraps to 0x1FFF.
    branch_en  = 1'b1;
    branch_off = 16'hFFFF;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h1FFF) begin
      n_fail++; $display("FAIL branch_wrap: got pc=%h exp 1fff", pc_out);
    end
  endtask

  task automatic test_call_ret();
    goto_pc(13'h050);
    call_en     = 1'b1;
    jump_target = 13'h200;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h200 || ras_count !== CW'(1) || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL call: got pc=%h cnt=%0d redir=%b exp 200/1/1", pc_out, ras_count, redirect);
    end
    ret_en = 1'b1;
    tick();
    n_checks++;
    if (pc_out !== 13'h051 || ras_count !== '0 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL ret: got pc=%h cnt=%0d redir=%b exp 051/0/1", pc_out, ras_count, redirect);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h052 || ras_underflow !== 1'b1 || redirect !== 1'b0 || ras_count !== '0) begin
      n_fail++;
      $display("FAIL ret_empty: got pc=%h unf=%b redir=%b cnt=%0d exp 052/1/0/0",
               pc_out, ras_underflow, redirect, ras_count);
    end
    tick();
    n_checks++;
    if (ras_underflow !== 1'b0 || pc_out !== 13'h053) begin
      n_fail++; $display("FAIL unf_pulse: got unf=%b pc=%h exp 0/053", ras_underflow, pc_out);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] ret_exp [4];
    ret_exp[0] = 13'h051;
    ret_exp[1] = 13'h041;
    ret_exp[2] = 13'h031;
    ret_exp[3] = 13'h021;
    for (int i = 1; i <= 5; i++) begin
      goto_pc(AW'(i * 16));
      call_en     = 1'b1;
      jump_target = 13'h300;
      tick();
      idle_inputs();
      n_checks++;
      if (ras_count !== CW'((i > 4) ? 4 : i) || ras_overflow !== (i == 5)) begin
        n_fail++;
        $display("FAIL call_%0d: got cnt=%0d ovf=%b exp cnt=%0d ovf=%b",
                 i, ras_count, ras_overflow, (i > 4) ? 4 : i, (i == 5));
      end
    end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1'b1;
      tick();
      idle_inputs();
      n_checks++;
      if (pc_out !== ret_exp[i] || ras_count !== CW'(3 - i) || ras_overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL ret_%0d: got pc=%h cnt=%0d ovf=%b exp pc=%h cnt=%0d ovf=0",
                 i, pc_out, ras_count, ras_overflow, ret_exp[i], 3 - i);
      end
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] held;
    goto_pc(13'h0C0);
    call_en     = 1'b1;
    jump_target = 13'h0D0;
    tick();
    idle_inputs();
    held        = pc_out;
    pc_write    = 1'b0;
    jump_en     = 1'b1;
    jump_target = 13'h777;
    tick();
    n_checks++;
    if (pc_out !== 13'h0D0 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL stall_jump: got pc=%h redir=%b exp 0d0/0", pc_out, redirect);
    end
    jump_en = 1'b0;
    call_en = 1'b1;
    tick();
    call_en = 1'b0;
    ret_en  = 1'b1;
    tick();
    n_checks++;
    if (pc_out !== held || ras_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL stall_ras: got pc=%h cnt=%0d exp 0d0/1", pc_out, ras_count);
    end
    ret_en  = 1'b0;
    exc_req = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h004 || redirect !== 1'b1 || ras_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL stall_exc: got pc=%h redir=%b cnt=%0d exp 004/1/1", pc_out, redirect, ras_count);
    end
    // Exception beats a simultaneous call; RAS untouched.
    exc_req     = 1'b1;
    call_en     = 1'b1;
    jump_target = 13'h555;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h004 || ras_count !== CW'(1)) begin
      n_fail++; $display("FAIL exc_over_call: got pc=%h cnt=%0d exp 004/1", pc_out, ras_count);
    end
    // Return still sees the entry pushed before the stall (0x0C0 + 1).
    ret_en = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h0C1 || ras_count !== '0) begin
      n_fail++; $display("FAIL stall_ret: got pc=%h cnt=%0d exp 0c1/0", pc_out, ras_count);
    end
  endtask

  task automatic test_priority();
    goto_pc(13'h080);
    jump_en     = 1'b1;
    call_en     = 1'b1;
    branch_en   = 1'b1;
    jump_target = 13'h123;
    branch_off  = 16'h0010;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h123 || ras_count !== '0 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_jump: got pc=%h cnt=%0d redir=%b exp 123/0/1", pc_out, ras_count, redirect);
    end
    // Call beats return and branch.
    call_en     = 1'b1;
    ret_en      = 1'b1;
    branch_en   = 1'b1;
    jump_target = 13'h400;
    branch_off  = 16'h0010;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h400 || ras_count !== CW'(1)) begin
      n_fail++; $display("FAIL prio_call: got pc=%h cnt=%0d exp 400/1", pc_out, ras_count);
    end
    // Return beats branch.
    ret_en     = 1'b1;
    branch_en  = 1'b1;
    branch_off = 16'h0010;
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h124 || ras_count !== '0) begin
      n_fail++; $display("FAIL prio_ret: got pc=%h cnt=%0d exp 124/0", pc_out, ras_count);
    end
  endtask

  task automatic test_back_to_back();
    goto_pc(13'h600);
    call_en     = 1'b1;
    jump_target = 13'h700;
    tick();
    jump_target = 13'h800;
    tick();
    call_en = 1'b0;
    ret_en  = 1'b1;
    tick();
    n_checks++;
    if (pc_out !== 13'h701 || ras_count !== CW'(1)) begin
      n_fail++; $display("FAIL b2b_ret1: got pc=%h cnt=%0d exp 701/1", pc_out, ras_count);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (pc_out !== 13'h601 || ras_count !== '0 || redirect !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ret2: got pc=%h cnt=%0d redir=%b exp 601/0/1", pc_out, ras_count, redirect);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
